// File: rtl/conv_window_gen.sv
// Streams raster-scan pixels through two line buffers and a 3x3 window register,
// emitting every fully populated window with its top-left image coordinate.
module conv_window_gen #(
    parameter int DATA_WIDTH  = 8,
    parameter int FILTER_SIZE = 3,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [DATA_WIDTH-1:0]                                pixel_in,
    input  logic                                                 pixel_valid,
    output logic                                                 pixel_ready,
    output logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][DATA_WIDTH-1:0] image_patch,
    output logic                                                 patch_valid,
    input  logic                                                 patch_ready,
    output logic [$clog2(IMG_HEIGHT)-1:0]                        patch_row,
    output logic [$clog2(IMG_WIDTH)-1:0]                         patch_col,
    output logic                                                 frame_done
);

    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    // Handshake: a pixel transfers on a rising edge where pixel_valid && pixel_ready;
    // a window transfers where patch_valid && patch_ready. pixel_ready is combinational.

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DATA_WIDTH-1:0] lb0_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;
    logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][DATA_WIDTH-1:0] win_q, win_d;
    logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][DATA_WIDTH-1:0] patch_q, patch_d;
    logic          patch_valid_q, patch_valid_d;
    logic [RW-1:0] patch_row_q, patch_row_d;
    logic [CW-1:0] patch_col_q, patch_col_d;
    logic          frame_done_q, frame_done_d;
    logic          accept, load;

    assign pixel_ready = !patch_valid_q || patch_ready;
    assign accept      = pixel_valid && pixel_ready;
    assign load        = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign lb0_rd      = lb0_q[col_q];
    assign lb1_rd      = lb1_q[col_q];

    always_comb begin
        col_d         = col_q;
        row_d         = row_q;
        frame_done_d  = 1'b0;
        win_d         = win_q;
        patch_d       = patch_q;
        patch_valid_d = patch_valid_q;
        patch_row_d   = patch_row_q;
        patch_col_d   = patch_col_q;
        if (accept) begin
            for (int r = 0; r < FILTER_SIZE; r++) begin
                for (int c = 0; c < FILTER_SIZE - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            win_d[0][FILTER_SIZE-1] = lb1_rd;
            win_d[1][FILTER_SIZE-1] = lb0_rd;
            win_d[2][FILTER_SIZE-1] = pixel_in;
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        // A new load wins over a consume so the slot never empties between windows.
        if (load) begin
            patch_d       = win_d;
            patch_valid_d = 1'b1;
            patch_row_d   = row_q - RW'(2);
            patch_col_d   = col_q - CW'(2);
        end else if (patch_ready) begin
            patch_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q         <= '0;
            row_q         <= '0;
            patch_q       <= '0;
            patch_valid_q <= 1'b0;
            patch_row_q   <= '0;
            patch_col_q   <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            patch_q       <= patch_d;
            patch_valid_q <= patch_valid_d;
            patch_row_q   <= patch_row_d;
            patch_col_q   <= patch_col_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // Line buffers and the window need no reset: a window is only emitted once
    // every element has been rewritten with pixels of the current frame.
    always_ff @(posedge clk) begin
        win_q <= win_d;
        if (accept) begin
            lb1_q[col_q] <= lb0_rd;
            lb0_q[col_q] <= pixel_in;
        end
    end

    assign image_patch = patch_q;
    assign patch_valid = patch_valid_q;
    assign patch_row   = patch_row_q;
    assign patch_col   = patch_col_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: an image model pushes expected windows into a queue
// as pixels are accepted; a monitor pops and compares on each window transfer.
module tb_conv_window_gen;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int IH = 8;
    localparam int W  = 3 + 3 + 9 * DW;

    logic                         clk;
    logic                         rst;
    logic [DW-1:0]                pixel_in;
    logic                         pixel_valid;
    logic                         pixel_ready;
    logic [2:0][2:0][DW-1:0]      image_patch;
    logic                         patch_valid;
    logic                         patch_ready;
    logic [2:0]                   patch_row;
    logic [2:0]                   patch_col;
    logic                         frame_done;

    int checks   = 0;
    int failures = 0;
    int patch_cnt = 0;
    int fd_cnt    = 0;
    int m_row = 0;
    int m_col = 0;
    int img [IH][IW];
    logic [W-1:0] exp_q [$];

    conv_window_gen #(
        .DATA_WIDTH(DW), .FILTER_SIZE(3), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
    ) dut (
        .clk(clk), .rst(rst),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .image_patch(image_patch), .patch_valid(patch_valid), .patch_ready(patch_ready),
        .patch_row(patch_row), .patch_col(patch_col), .frame_done(frame_done)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && patch_valid && patch_ready) begin
                act = {patch_row, patch_col, image_patch};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_patch got row=%0d col=%0d, expected no patch", patch_row, patch_col);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        failures++;
                        $display("FAIL patch_data got %h expected %h", act, exp);
                    end
                end
                patch_cnt++;
            end
            if (!rst && frame_done) fd_cnt++;
        end
    end

    // ---------------- driver ----------------
    task automatic model_reset();
        m_row = 0;
        m_col = 0;
        exp_q.delete();
    endtask

    task automatic send_pixel(input logic [DW-1:0] v);
        int guard;
        logic was_last;
        logic [2:0][2:0][DW-1:0] p;
        guard = 0;
        pixel_in    = v;
        pixel_valid = 1'b1;
        @(negedge clk);
        while (!pixel_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            failures++;
            $display("FAIL pixel_ready_timeout got ready=0 for 200 cycles, expected 1");
            pixel_valid = 1'b0;
            return;
        end
        img[m_row][m_col] = int'(v);
        if (m_row >= 2 && m_col >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    p[r][c] = DW'(img[m_row-2+r][m_col-2+c]);
            exp_q.push_back({3'(m_row - 2), 3'(m_col - 2), p});
        end
        was_last = (m_row == IH - 1) && (m_col == IW - 1);
        if (m_col == IW - 1) begin
            m_col = 0;
            m_row = (m_row == IH - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        checks++;
        if (frame_done !== was_last) begin
            failures++;
            $display("FAIL frame_done got %b expected %b", frame_done, was_last);
        end
    endtask

    task automatic drain_and_count(input string name, input int exp_patches, input int exp_fd);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (patch_cnt !== exp_patches) begin
            failures++;
            $display("FAIL %s_patch_count got %0d expected %0d", name, patch_cnt, exp_patches);
        end
        checks++;
        if (fd_cnt !== exp_fd) begin
            failures++;
            $display("FAIL %s_frame_done_count got %0d expected %0d", name, fd_cnt, exp_fd);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL %s_leftover got %0d queued expected 0", name, exp_q.size());
        end
        patch_cnt = 0;
        fd_cnt    = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        pixel_valid = 1'b0;
        pixel_in = '0;
        patch_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (patch_valid !== 1'b0) begin failures++; $display("FAIL reset_patch_valid got %b expected 0", patch_valid); end
        checks++;
        if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got %b expected 0", frame_done); end
        checks++;
        if (patch_row !== 3'd0 || patch_col !== 3'd0) begin
            failures++; $display("FAIL reset_row_col got %0d,%0d expected 0,0", patch_row, patch_col);
        end
        checks++;
        if (image_patch !== '0) begin failures++; $display("FAIL reset_image_patch got %h expected 0", image_patch); end
        checks++;
        if (pixel_ready !== 1'b1) begin failures++; $display("FAIL reset_pixel_ready got %b expected 1", pixel_ready); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_streaming();
        logic [2:0][2:0][DW-1:0] first_exp;
        logic [2:0][2:0][DW-1:0] last_exp;
        int sum;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                first_exp[r][c] = DW'(r * 8 + c);
                last_exp[r][c]  = DW'((5 + r) * 8 + 5 + c);
            end
        patch_ready = 1'b1;
        for (int i = 0; i < IW * IH; i++) begin
            send_pixel(DW'(i));
            if (i == 17) begin
                checks++;
                if (patch_valid !== 1'b0) begin failures++; $display("FAIL early_patch got valid=%b expected 0", patch_valid); end
            end
            if (i == 18) begin
                checks++;
                if (patch_valid !== 1'b1 || patch_row !== 3'd0 || patch_col !== 3'd0 || image_patch !== first_exp) begin
                    failures++;
                    $display("FAIL first_patch got v=%b r=%0d c=%0d %h expected v=1 r=0 c=0 %h",
                             patch_valid, patch_row, patch_col, image_patch, first_exp);
                end
                sum = 0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) sum += int'(image_patch[r][c]);
                checks++;
                if (sum !== 81) begin failures++; $display("FAIL first_patch_sum got %0d expected 81", sum); end
            end
            if (i == IW * IH - 1) begin
                checks++;
                if (patch_valid !== 1'b1 || patch_row !== 3'd5 || patch_col !== 3'd5 || image_patch !== last_exp) begin
                    failures++;
                    $display("FAIL last_patch got v=%b r=%0d c=%0d %h expected v=1 r=5 c=5 %h",
                             patch_valid, patch_row, patch_col, image_patch, last_exp);
                end
            end
        end
        drain_and_count("stream", 36, 1);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        int g;
        patch_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < IW * IH; i++) send_pixel(DW'(i * 5 + 3));
            end
            begin
                g = 0;
                @(negedge clk);
                while (!patch_valid && g < 400) begin
                    @(negedge clk);
                    g++;
                end
                checks++;
                if (!patch_valid) begin
                    failures++;
                    $display("FAIL bp_wait_patch got no patch expected patch_valid=1");
                end
                held = {patch_row, patch_col, image_patch};
                repeat (5) begin
                    @(negedge clk);
                    checks++;
                    if (pixel_ready !== 1'b0) begin failures++; $display("FAIL bp_pixel_ready got %b expected 0", pixel_ready); end
                    checks++;
                    if ({patch_row, patch_col, image_patch} !== held || patch_valid !== 1'b1) begin
                        failures++;
                        $display("FAIL bp_hold got %h expected %h", {patch_row, patch_col, image_patch}, held);
                    end
                end
                @(posedge clk);
                #1;
                patch_ready = 1'b1;
            end
        join
        drain_and_count("backpressure", 36, 1);
    endtask

    task automatic test_bubbles();
        patch_ready = 1'b1;
        for (int i = 0; i < IW * IH; i++) begin
            repeat ($urandom_range(0, 2)) begin
                pixel_valid = 1'b0;
                pixel_in = DW'($urandom_range(0, 255));
                @(posedge clk);
                #1;
            end
            send_pixel(DW'(i));
        end
        drain_and_count("bubble", 36, 1);
    endtask

    task automatic test_reset_mid_frame();
        patch_ready = 1'b1;
        for (int i = 0; i < 30; i++) send_pixel(DW'(i));
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (patch_valid !== 1'b0 || frame_done !== 1'b0 || patch_row !== 3'd0 || patch_col !== 3'd0 || image_patch !== '0) begin
            failures++;
            $display("FAIL midreset_state got v=%b fd=%b r=%0d c=%0d %h expected all 0",
                     patch_valid, frame_done, patch_row, patch_col, image_patch);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        patch_cnt = 0;
        fd_cnt    = 0;
        for (int i = 0; i < IW * IH; i++) send_pixel(8'hFF);
        drain_and_count("midreset", 36, 1);
    endtask

    task automatic test_back_to_back();
        patch_ready = 1'b1;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < IW * IH; i++) send_pixel(DW'(f));
        drain_and_count("b2b", 72, 2);
    endtask

    initial begin
        test_reset();
        @(posedge clk);
        #1;
        test_streaming();
        test_backpressure();
        test_bubbles();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the pixel width; it is taken from ai_accelerator_pkg.
REQ-002 SHALL have parameter FILTER_SIZE, default 3, meaning the window edge; only the value 3 is supported.
REQ-003 SHALL have parameter IMG_WIDTH, default 8, meaning pixels per line (range 3..1024).
REQ-004 SHALL have parameter IMG_HEIGHT, default 8, meaning lines per frame (range 3..1024).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port pixel_in, input, DATA_WIDTH: raster-scan pixel, unsigned.
REQ-008 SHALL have port pixel_valid, input, 1 bit: pixel_in is valid.
REQ-009 SHALL have port pixel_ready, output, 1 bit: the block accepts a pixel this cycle.
REQ-010 SHALL have port image_patch, output, [FILTER_SIZE][FILTER_SIZE] x DATA_WIDTH: 3x3 window that feeds accelerator_for_conv2d.image_patch.
REQ-011 SHALL have port patch_valid, output, 1 bit: image_patch holds a valid window.
REQ-012 SHALL have port patch_ready, input, 1 bit: downstream consumes the window.
REQ-013 SHALL have port patch_row, output, clog2(IMG_HEIGHT) bits: image row of image_patch[0][0].
REQ-014 SHALL have port patch_col, output, clog2(IMG_WIDTH) bits: image column of image_patch[0][0].
REQ-015 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-016 SHALL accept a pixel when pixel_valid && pixel_ready; pixel_ready = !patch_valid || patch_ready (single output slot, combinational ready path).
REQ-017 SHALL track the accepted pixel position with counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1); col increments on every accept; on col=IMG_WIDTH-1, col wraps to 0 and row increments.
REQ-018 SHALL, on accepting (row=IMG_HEIGHT-1, col=IMG_WIDTH-1), wrap row and col to 0 and pulse frame_done high for exactly the next cycle.
REQ-019 SHALL keep two line buffers of IMG_WIDTH entries each; on accept: lb1[col] <= lb0[col] (old value), lb0[col] <= pixel_in.
REQ-020 SHALL keep a 3x3 window register; on accept, columns shift left and the new right column is {lb1[col], lb0[col], pixel_in} for rows 0,1,2.
REQ-021 SHALL, on an accept at row>=2 and col>=2, register the updated window into image_patch with patch_valid=1 on the next cycle; image_patch[r][c] = pixel(row-2+r, col-2+c).
REQ-022 SHALL set patch_row=row-2 and patch_col=col-2, registered together with image_patch.
REQ-023 SHALL produce no window when row<2 or col<2 (no padding); a frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
REQ-024 SHALL clear patch_valid when patch_ready=1 and no new window is loaded in the same cycle; a simultaneous consume and new load leaves patch_valid=1 with the new data.
REQ-025 SHALL hold image_patch, patch_row and patch_col stable while patch_valid=1 and patch_ready=0.
REQ-026 SHALL give a latency of 1 cycle from the accepting edge to patch_valid; with patch_ready tied high it sustains 1 pixel per cycle.
REQ-027 SHALL ensure back-to-back frames produce no window mixing frames; stale line-buffer data from a previous frame is never emitted.

Reset
REQ-028 SHALL, while rst=1, set row, col, patch_valid, frame_done, patch_row, patch_col and every image_patch element to 0; line-buffer contents are don't-care.
REQ-029 SHALL, on rst asserted mid-frame, discard any pending window; the first pixel accepted after release is position (0,0).

Verification
REQ-030 SHALL pass a streaming test: 8x8 frame, pixel = row*8+col, patch_ready=1 -> first patch_valid one cycle after the 19th accept, with rows {0,1,2},{8,9,10},{16,17,18}, patch_row=0, patch_col=0; the all-ones filter downstream gives 81.
REQ-031 SHALL pass a count test: same frame -> exactly 36 patches; the last patch is {45,46,47},{53,54,55},{61,62,63} at (5,5); frame_done pulses once, one cycle after the 64th accept.
REQ-032 SHALL pass a backpressure test: patch_ready=0 for 5 cycles while the first patch is valid -> pixel_ready=0 and the patch is unchanged; on patch_ready=1 the stream resumes with no lost or duplicated pixel.
REQ-033 SHALL pass a bubble test: pixel_valid toggling randomly -> patch sequence and values identical to REQ-030/REQ-031.
REQ-034 SHALL pass a reset test: rst pulsed after 30 pixels, then a full frame of value 255 -> all 36 patches are all 255 and patch_row/patch_col restart at 0.
REQ-035 SHALL pass a back-to-back test: frame A = 0s, then frame B = 1s with no gap -> every frame-B patch is all 1s.
